// File: rtl/vle_pkg.sv
// Shared state type and sizing helpers for the vle_pack variable-length bit packer.
package vle_pkg;

   typedef enum logic {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } state_t;

   function automatic int len_w(input int n);
      return $clog2(n + 1);
   endfunction

   // Accumulator holds one full output word plus the widest possible codeword.
   function automatic int acc_w(input int out_w, input int code_w);
      return out_w + code_w;
   endfunction

endpackage

// File: rtl/vle_insert.sv
// Combinational mask-and-shift: drops a codeword into the accumulator directly below the fill point.
module vle_insert
   import vle_pkg::*;
#(
   parameter int CODE_W = 32,
   parameter int ACC_W  = 64,
   parameter int FILL_W = 7,
   parameter int LEN_W  = 6
) (
   input  logic [ACC_W-1:0]  i_acc,
   input  logic [FILL_W-1:0] i_fill,
   input  logic [CODE_W-1:0] i_code,
   input  logic [LEN_W-1:0]  i_len,
   output logic [ACC_W-1:0]  o_merged
);

   logic [ACC_W-1:0]  w_mask;
   logic [ACC_W-1:0]  w_code;
   logic [FILL_W-1:0] w_shamt;

   assign w_mask  = (ACC_W'(1) << i_len) - ACC_W'(1);
   assign w_code  = ACC_W'(i_code) & w_mask;
   // Caller guarantees i_fill + i_len <= ACC_W, so this never underflows.
   assign w_shamt = FILL_W'(ACC_W) - i_fill - FILL_W'(i_len);
   assign o_merged = i_acc | (w_code << w_shamt);

endmodule

// File: rtl/vle_pack.sv
// Variable-length codeword packer: MSB-first concatenation into OUT_W-bit words with flush/last.
// Optional statistics counters (bit_count, word_count) are built when VLE_PACK_STATS_EN is defined.
module vle_pack
   import vle_pkg::*;
#(
   parameter int  CODE_W = 32,
   parameter int  OUT_W  = 32,
   localparam int LEN_W  = len_w(CODE_W)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CODE_W-1:0] in_code,
   input  logic [LEN_W-1:0]  in_len,
   input  logic              in_flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  out_data,
   output logic              out_last
`ifdef VLE_PACK_STATS_EN
   ,
   output logic [31:0]       bit_count,
   output logic [31:0]       word_count
`endif
);

   localparam int                ACC_W  = acc_w(OUT_W, CODE_W);
   localparam int                FILL_W = $clog2(ACC_W + 1);
   localparam logic [FILL_W-1:0] OUT_F  = FILL_W'(OUT_W);

   logic [ACC_W-1:0]  r_acc;
   logic [FILL_W-1:0] r_fill;
   state_t            r_state;
   logic              r_out_valid;
   logic              r_out_last;
   logic [OUT_W-1:0]  r_out_data;

   logic              w_in_hs;
   logic              w_out_hs;
   logic [LEN_W-1:0]  w_len;
   logic [ACC_W-1:0]  w_acc_sh;
   logic [FILL_W-1:0] w_fill_sh;
   logic [FILL_W-1:0] w_fill_app;
   logic [FILL_W-1:0] w_fill_round;
   logic [ACC_W-1:0]  w_merged;
   logic [ACC_W-1:0]  w_acc_next;
   logic [FILL_W-1:0] w_fill_next;
   state_t            w_state_next;

   assign in_ready  = (r_state == RUN) && (r_fill <= OUT_F);
   assign out_valid = r_out_valid;
   assign out_last  = r_out_last;
   assign out_data  = r_out_data;

   assign w_in_hs  = in_valid && in_ready;
   assign w_out_hs = r_out_valid && out_ready;
   assign w_len    = (in_len > LEN_W'(CODE_W)) ? LEN_W'(CODE_W) : in_len;

   // A word leaving this cycle is removed before the new code is placed.
   assign w_acc_sh  = w_out_hs ? (r_acc << OUT_W) : r_acc;
   assign w_fill_sh = !w_out_hs       ? r_fill :
                      (r_fill > OUT_F) ? (r_fill - OUT_F) : '0;

   assign w_fill_app   = w_fill_sh + FILL_W'(w_len);
   assign w_fill_round = FILL_W'(((32'(w_fill_app) + 32'(OUT_W - 1)) / 32'(OUT_W)) * 32'(OUT_W));

   vle_insert #(
      .CODE_W (CODE_W),
      .ACC_W  (ACC_W),
      .FILL_W (FILL_W),
      .LEN_W  (LEN_W)
   ) u_insert (
      .i_acc    (w_acc_sh),
      .i_fill   (w_fill_sh),
      .i_code   (in_code),
      .i_len    (w_len),
      .o_merged (w_merged)
   );

   always_comb begin
      w_acc_next   = r_acc;
      w_fill_next  = r_fill;
      w_state_next = r_state;
      if (w_out_hs) begin
         w_acc_next  = w_acc_sh;
         w_fill_next = w_fill_sh;
      end
      if (w_in_hs) begin
         w_acc_next  = w_merged;
         w_fill_next = w_fill_app;
         // Bits below fill are always zero, so rounding fill up is the zero pad.
         if (in_flush && (w_fill_app != '0)) begin
            w_fill_next  = w_fill_round;
            w_state_next = DRAIN;
         end
      end
      if ((r_state == DRAIN) && w_out_hs && (w_fill_sh == '0)) begin
         w_state_next = RUN;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc       <= '0;
         r_fill      <= '0;
         r_state     <= RUN;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_data  <= '0;
      end else begin
         r_acc       <= w_acc_next;
         r_fill      <= w_fill_next;
         r_state     <= w_state_next;
         r_out_valid <= (w_fill_next >= OUT_F) ||
                        ((w_state_next == DRAIN) && (w_fill_next != '0));
         r_out_last  <= (w_state_next == DRAIN) && (w_fill_next != '0) &&
                        (w_fill_next <= OUT_F);
         r_out_data  <= w_acc_next[ACC_W-1 -: OUT_W];
      end
   end

`ifdef VLE_PACK_STATS_EN
   logic [31:0] r_bit_count;
   logic [31:0] r_word_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bit_count  <= '0;
         r_word_count <= '0;
      end else begin
         if (w_in_hs) begin
            r_bit_count <= r_bit_count + 32'(w_len);
         end
         if (w_out_hs) begin
            r_word_count <= r_word_count + 32'd1;
         end
      end
   end

   assign bit_count  = r_bit_count;
   assign word_count = r_word_count;
`endif

endmodule

// File: tb/tb_vle_pack.sv
// Self-checking bench for vle_pack: directed vector table, corner sequences, random traffic vs a bit-queue model.
module tb_vle_pack;

   localparam int LEN_W = 6;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_code;
   logic [5:0]  in_len;
   logic        in_flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_last;

   always #5 clk = ~clk;

   vle_pack dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_code   (in_code),
      .in_len    (in_len),
      .in_flush  (in_flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last)
   );

   typedef struct {
      logic [31:0] data;
      logic        last;
   } word_t;

   typedef struct {
      logic [31:0] code;
      logic [5:0]  len;
      logic        flush;
      logic        exp_valid;
      logic [31:0] exp_data;
      logic        exp_last;
   } vec_t;

   int    n_cmp  = 0;
   int    n_fail = 0;
   bit    bits_q[$];
   word_t exp_q[$];
   bit    flush_pend = 1'b0;
   bit    stall_prev = 1'b0;
   logic [31:0] prev_data = '0;
   logic        prev_last = 1'b0;
   vec_t  vecs[14];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: the stream is a plain queue of bits; words are cut 32 at a time.
   task automatic model_push(input logic [31:0] code, input logic [5:0] len, input logic flush);
      int          l;
      logic [31:0] wd;
      word_t       w;
      l = (len > 6'd32) ? 32 : int'(len);
      for (int i = l - 1; i >= 0; i--) bits_q.push_back(code[i]);
      if (flush && bits_q.size() > 0) begin
         while (bits_q.size() % 32 != 0) bits_q.push_back(1'b0);
         flush_pend = 1'b1;
      end
      while (bits_q.size() >= 32) begin
         for (int i = 31; i >= 0; i--) wd[i] = bits_q.pop_front();
         w.data = wd;
         w.last = flush_pend && (bits_q.size() == 0);
         if (w.last) flush_pend = 1'b0;
         exp_q.push_back(w);
      end
   endtask

   task automatic model_clear();
      bits_q.delete();
      exp_q.delete();
      flush_pend = 1'b0;
      stall_prev = 1'b0;
   endtask

   task automatic monitor();
      word_t w;
      if (rst_n !== 1'b1) return;
      if (stall_prev) begin
         check("hold_valid", 64'(out_valid), 64'(1));
         check("hold_data", 64'(out_data), 64'(prev_data));
         check("hold_last", 64'(out_last), 64'(prev_last));
      end
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_word", 64'(out_data), 64'hDEAD_0000_0000);
         end else begin
            w = exp_q.pop_front();
            check("word_data", 64'(out_data), 64'(w.data));
            check("word_last", 64'(out_last), 64'(w.last));
         end
         $display("word %08h last=%0b", out_data, out_last);
      end
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      if (in_valid && in_ready) model_push(in_code, in_len, in_flush);
   endtask

   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] code, input logic [5:0] len, input logic flush);
      in_valid = 1'b1;
      in_code  = code;
      in_len   = len;
      in_flush = flush;
      @(negedge clk);
      check("send_in_ready", 64'(in_ready), 64'(1));
      monitor();
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   initial begin
      bit accepted;

      vecs[0]  = '{32'hA1,       6'd8,  1'b0, 1'b0, 32'h0,        1'b0};
      vecs[1]  = '{32'hB2,       6'd8,  1'b0, 1'b0, 32'h0,        1'b0};
      vecs[2]  = '{32'hC3,       6'd8,  1'b0, 1'b0, 32'h0,        1'b0};
      vecs[3]  = '{32'hD4,       6'd8,  1'b0, 1'b1, 32'hA1B2C3D4, 1'b0};
      vecs[4]  = '{32'hABCDE,    6'd20, 1'b0, 1'b0, 32'h0,        1'b0};
      vecs[5]  = '{32'h12345,    6'd20, 1'b0, 1'b1, 32'hABCDE123, 1'b0};
      vecs[6]  = '{32'h0,        6'd0,  1'b1, 1'b1, 32'h45000000, 1'b1};
      vecs[7]  = '{32'h5,        6'd3,  1'b1, 1'b1, 32'hA0000000, 1'b1};
      vecs[8]  = '{32'hFFFFFFFF, 6'd4,  1'b0, 1'b0, 32'h0,        1'b0};
      vecs[9]  = '{32'h0,        6'd28, 1'b0, 1'b1, 32'hF0000000, 1'b0};
      vecs[10] = '{32'hFFFFFFFF, 6'd0,  1'b0, 1'b0, 32'h0,        1'b0};
      vecs[11] = '{32'hFFFFFFFF, 6'd63, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0};
      vecs[12] = '{32'h0,        6'd0,  1'b1, 1'b0, 32'h0,        1'b0};
      vecs[13] = '{32'h3,        6'd2,  1'b1, 1'b1, 32'hC0000000, 1'b1};

      rst_n = 1'b0; in_valid = 1'b0; in_code = '0; in_len = '0; in_flush = 1'b0; out_ready = 1'b1;
      #22;
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_out_last", 64'(out_last), 64'(0));
      check("rst_out_data", 64'(out_data), 64'(0));
      check("rst_in_ready", 64'(in_ready), 64'(1));
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed table: one accept, then inspect the following cycle.
      for (int i = 0; i < 14; i++) begin
         send(vecs[i].code, vecs[i].len, vecs[i].flush);
         @(negedge clk);
         check("vec_valid", 64'(out_valid), 64'(vecs[i].exp_valid));
         if (vecs[i].exp_valid) begin
            check("vec_data", 64'(out_data), 64'(vecs[i].exp_data));
            check("vec_last", 64'(out_last), 64'(vecs[i].exp_last));
         end
         $display("vec %0d code=%08h len=%0d flush=%0b -> valid=%0b data=%08h last=%0b",
                  i, vecs[i].code, vecs[i].len, vecs[i].flush, out_valid, out_data, out_last);
         monitor();
         @(posedge clk);
         #1;
      end

      // Backpressure: a fifth code still fits at fill 32, then input stalls.
      out_ready = 1'b0;
      send(32'hA1, 6'd8, 1'b0);
      send(32'hB2, 6'd8, 1'b0);
      send(32'hC3, 6'd8, 1'b0);
      send(32'hD4, 6'd8, 1'b0);
      send(32'hE5, 6'd8, 1'b0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("bp_in_ready", 64'(in_ready), 64'(0));
         check("bp_data", 64'(out_data), 64'hA1B2C3D4);
         monitor();
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      tick();
      @(negedge clk);
      check("bp_release_in_ready", 64'(in_ready), 64'(1));
      check("bp_release_valid", 64'(out_valid), 64'(0));
      monitor();
      @(posedge clk);
      #1;
      send(32'h0, 6'd0, 1'b1);
      @(negedge clk);
      check("bp_remainder", 64'(out_data), 64'hE5000000);
      check("bp_remainder_last", 64'(out_last), 64'(1));
      monitor();
      @(posedge clk);
      #1;
      $display("backpressure sequence done");

      // Flush: in_ready stays low until the padded word is taken.
      out_ready = 1'b0;
      send(32'h5, 6'd3, 1'b1);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check("fl_in_ready", 64'(in_ready), 64'(0));
         check("fl_data", 64'(out_data), 64'hA0000000);
         check("fl_last", 64'(out_last), 64'(1));
         monitor();
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("fl_hs_in_ready", 64'(in_ready), 64'(0));
      monitor();
      @(posedge clk);
      #1;
      @(negedge clk);
      check("fl_after_in_ready", 64'(in_ready), 64'(1));
      check("fl_after_valid", 64'(out_valid), 64'(0));
      monitor();
      @(posedge clk);
      #1;
      $display("flush sequence done");

      // Reset while draining a 40-bit flushed stream.
      out_ready = 1'b0;
      send(32'h11, 6'd8, 1'b0);
      send(32'h22, 6'd8, 1'b0);
      send(32'h33, 6'd8, 1'b0);
      send(32'h44, 6'd8, 1'b0);
      send(32'h55, 6'd8, 1'b1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      tick();
      check("drain_pre_last", 64'(out_last), 64'(1));
      rst_n = 1'b0;
      #2;
      check("drain_rst_valid", 64'(out_valid), 64'(0));
      check("drain_rst_last", 64'(out_last), 64'(0));
      check("drain_rst_data", 64'(out_data), 64'(0));
      model_clear();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("post_rst_valid", 64'(out_valid), 64'(0));
         check("post_rst_in_ready", 64'(in_ready), 64'(1));
         monitor();
         @(posedge clk);
         #1;
      end
      $display("reset-in-drain sequence done");

      // Random traffic against the bit-queue model.
      for (int c = 0; c < 3000; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_code   = $urandom();
         in_len    = LEN_W'($urandom_range(0, 40));
         in_flush  = ($urandom_range(0, 15) == 0);
         out_ready = ($urandom_range(0, 3) != 0);
         tick();
      end

      in_valid = 1'b1; in_code = '0; in_len = '0; in_flush = 1'b1; out_ready = 1'b1;
      accepted = 1'b0;
      for (int k = 0; k < 50 && !accepted; k++) begin
         @(negedge clk);
         accepted = in_ready;
         monitor();
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0; in_flush = 1'b0;
      check("final_flush_accept", 64'(accepted), 64'(1));
      for (int k = 0; k < 20 && (exp_q.size() != 0 || out_valid); k++) tick();
      check("final_words_left", 64'(exp_q.size()), 64'(0));
      check("final_bits_left", 64'(bits_q.size()), 64'(0));
      check("final_out_valid", 64'(out_valid), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/vle_pack.md
Name: vle_pack

Overview:
- Bit packer downstream of the binary/length encoding stage.
- Accepts variable-length codewords (LSB-aligned code plus bit length) over a valid/ready handshake.
- Concatenates them MSB-first into a continuous bitstream and emits fixed-width words over a second valid/ready handshake.
- A flush request pads the final partial word with zeros and marks it last.

Parameters:
- CODE_W, 32, maximum codeword length in bits.
- OUT_W, 32, output word width in bits.
- LEN_W, $clog2(CODE_W+1), width of the length field (derived; do not override).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  codeword valid.
- in_ready  output  1  packer can accept a codeword.
- in_code  input  CODE_W  codeword, LSB-aligned; bits at or above in_len are ignored.
- in_len  input  LEN_W  codeword length, 0..CODE_W.
- in_flush  input  1  sideband qualified by the input handshake: pad and drain after this code.
- out_valid  output  1  out_data holds a complete word.
- out_ready  input  1  consumer accepts the word.
- out_data  output  OUT_W  packed word; first-arrived bit at the MSB.
- out_last  output  1  final word of a flushed stream.

Behaviour:
- Clocking and reset: one clock domain; reset is asynchronous, active-low on rst_n.
- Storage: accumulator acc of ACC_W = OUT_W + CODE_W bits, and fill counter 0..ACC_W. Valid bits occupy acc[ACC_W-1 -: fill].
- Reset values: acc = 0, fill = 0, state = RUN, out_valid = 0, out_last = 0, out_data = 0, in_ready = 1.
- in_ready = (state == RUN) && (fill <= OUT_W). This guarantees any code fits.
- Input handshake (in_valid && in_ready):
  - Mask in_code to in_len bits.
  - Insert it at acc positions directly below the existing fill.
  - fill += in_len.
  - in_len > CODE_W is clamped to CODE_W.
  - in_len = 0 without flush: no state change.
- out_valid is registered and asserted when fill >= OUT_W, or when in DRAIN with fill > 0.
  - out_data = acc[ACC_W-1 -: OUT_W].
  - Latency: code accepted in cycle t; word visible in cycle t+1.
- Output handshake (out_valid && out_ready): shift acc left by OUT_W, zero-fill, fill -= OUT_W (saturating at 0 in DRAIN).
- Simultaneous input and output handshake in one cycle: the shift is applied first, then the new code is inserted at fill - OUT_W.
- Backpressure: while out_valid && !out_ready, out_data and out_last are held stable.
- State machine:
  - RUN: on an accepted code with in_flush = 1:
    - post-append fill > 0: round fill up to the next multiple of OUT_W (pad bits are zero) and go to DRAIN.
    - post-append fill == 0: stay in RUN; emit nothing.
  - DRAIN: in_ready = 0. Emit remaining words. out_last = 1 on the word whose handshake makes fill 0. Then return to RUN (in_ready reasserts the next cycle).
- Reset mid-operation (any state): return to reset values immediately. Buffered bits are discarded.

Optional Feature:
- Macro: VLE_PACK_STATS_EN.
- Defined:
  - Adds output port bit_count (32 bits).
  - bit_count counts payload bits (sum of accepted in_len, pad excluded); it wraps modulo 2^32 and resets to 0.
  - Adds output port word_count (32 bits): number of completed output handshakes.
- Undefined: neither port nor its counters exists; all other behaviour is identical.

Decomposition:
- Package vle_pkg holds:
  - the state enum (RUN, DRAIN);
  - a len_w(n) constant function returning $clog2(n+1);
  - the ACC_W derivation.
- One natural sub-module, vle_insert (combinational mask-and-shift):
  - inputs: acc, fill, code, len;
  - output: merged accumulator.
  - It keeps barrel-shift logic out of the FSM/handshake file.

Test Plan:
- Four codes, len 8 each: 0xA1, 0xB2, 0xC3, 0xD4, out_ready = 1 -> one word 0xA1B2C3D4 the cycle after the 4th accept; out_last = 0; fill = 0.
- Straddle: len 20 0xABCDE, then len 20 0x12345 -> word 0xABCDE123; fill = 8; held bits 0x45.
- Flush: len 3 code 0b101 with in_flush = 1 -> word 0xA0000000, out_last = 1; in_ready = 0 until the handshake, then 1 next cycle.
- Backpressure: out_ready = 0, four len-8 codes, then a fifth len-8 code:
  - after the four codes (fill = 32): in_ready stays 1 and the fifth code is accepted;
  - after the fifth code: in_ready = 0 and out_data is stable;
  - on release: 0xA1B2C3D4 followed by correct remainder alignment.
- Masking/clamp: in_code = 0xFFFFFFFF len 4, then len 28 zero -> word 0xF0000000. len 0 without flush -> no change.
- Reset in DRAIN (after a flush of a 40-bit stream): rst_n low mid-drain -> out_valid = 0, out_last = 0, in_ready = 1 after release; no residual words.
